// File: rtl/mdu_pkg.sv
// Shared types, constants and arithmetic helpers for the RV32M multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_XLEN  = 32;
    localparam int unsigned MDU_ITER  = 32;
    localparam int unsigned CNT_W     = $clog2(MDU_ITER);
    localparam logic [MDU_XLEN-1:0] DIV_OVF_Q = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Two's complement negate, 32 bits.
    function automatic logic [MDU_XLEN-1:0] neg32(input logic [MDU_XLEN-1:0] x);
        return ~x + 32'd1;
    endfunction

    // Two's complement negate, 64 bits.
    function automatic logic [2*MDU_XLEN-1:0] neg64(input logic [2*MDU_XLEN-1:0] x);
        return ~x + 64'd1;
    endfunction

    // Magnitude of x when treated as signed, otherwise x unchanged.
    function automatic logic [MDU_XLEN-1:0] abs32(input logic [MDU_XLEN-1:0] x,
                                                  input logic              is_signed);
        return (is_signed && x[MDU_XLEN-1]) ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned DW = 2 * XLEN;

    mdu_state_e      r_state;
    mdu_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]   r_acc;
    logic [XLEN-1:0] r_b;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [XLEN-1:0] r_result;
    logic            r_done;

    logic            w_is_div, w_is_rem, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_div_zero, w_div_ovf, w_special, w_neg_start, w_busy;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;
    logic [XLEN:0]   w_mul_sum, w_div_part, w_div_diff;
    logic [DW-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
    logic [XLEN-1:0] w_mul_res, w_div_raw, w_div_res, w_calc_res;

    // Operand decode, sign handling and single-cycle special cases at start.
    always_comb begin
        w_is_div   = funct3[2];
        w_is_rem   = funct3[2] & funct3[1];
        w_a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                     (funct3 == OP_DIV)  || (funct3 == OP_REM);
        w_b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
        w_sa       = w_a_signed & opr_a[XLEN-1];
        w_sb       = w_b_signed & opr_b[XLEN-1];
        w_mag_a    = abs32(opr_a, w_a_signed);
        w_mag_b    = abs32(opr_b, w_b_signed);
        // Remainder follows the dividend; product/quotient negate on sign mismatch.
        w_neg_start = w_is_rem ? w_sa : (w_sa ^ w_sb);
        w_div_zero = w_is_div && (opr_b == '0);
        w_div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                     (opr_a == DIV_OVF_Q) && (opr_b == '1);
        w_special  = w_div_zero | w_div_ovf;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? opr_a : '1;
        end else begin
            w_special_res = funct3[1] ? '0 : DIV_OVF_Q;
        end
    end

    // One shift-add or restoring-subtract step plus final sign correction.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[DW-1:XLEN]} + {1'b0, r_b};
        w_mul_nxt  = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[DW-1:1]};
        w_div_part = r_acc[DW-1:XLEN-1];
        w_div_diff = w_div_part - {1'b0, r_b};
        w_div_nxt  = w_div_diff[XLEN] ? {r_acc[DW-2:0], 1'b0}
                                      : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_acc_nxt  = r_op[2] ? w_div_nxt : w_mul_nxt;
        w_prod     = r_neg ? neg64(w_acc_nxt) : w_acc_nxt;
        w_mul_res  = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[DW-1:XLEN];
        w_div_raw  = r_op[1] ? w_acc_nxt[DW-1:XLEN] : w_acc_nxt[XLEN-1:0];
        w_div_res  = r_neg ? neg32(w_div_raw) : w_div_raw;
        w_calc_res = r_op[2] ? w_div_res : w_mul_res;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_nxt = w_special ? ST_DONE : ST_CALC;
                ST_CALC: if (r_cnt == '0) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Stall request: low in DONE so the pipeline advances while capturing result.
    always_comb begin
        w_busy = 1'b0;
        if (((r_state == ST_IDLE) && start && !flush) || (r_state == ST_CALC)) begin
            w_busy = 1'b1;
        end
    end

    // Datapath: latch operands on start, iterate in CALC, load result on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == ST_DONE);
            if (!flush) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_op  <= funct3;
                            r_b   <= w_mag_b;
                            r_neg <= w_neg_start;
                            r_acc <= {{XLEN{1'b0}}, w_mag_a};
                            r_cnt <= CNT_W'(MDU_ITER - 1);
                            if (w_special) r_result <= w_special_res;
                        end
                    end
                    ST_CALC: begin
                        r_acc <= w_acc_nxt;
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else begin
                            r_result <= w_calc_res;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy   = w_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table, random ops against a reference model, abort sequences.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] opr_a = '0;
    logic [31:0] opr_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    mdu_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .opr_a(opr_a), .opr_b(opr_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference using wide native arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issue one op, push expectation, then wait (bounded) for done and score it.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int          cyc;
        logic        got, busy_ok;
        logic [31:0] e;
        @(negedge clk);
        funct3 = f; opr_a = a; opr_b = b; start = 1'b1;
        sb_q.push_back(exp);
        #1;
        check("busy_cycle0", 32'(busy), 32'd1);
        check("done_cycle0", 32'(done), 32'd0);
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check("done_seen", 32'(got), 32'd1);
        check("busy_while_calc", 32'(busy_ok), 32'd1);
        if (got) begin
            check("latency", 32'(cyc), 32'(lat));
            check("busy_at_done", 32'(busy), 32'd0);
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: done with no expected entry");
            end else begin
                e = sb_q.pop_front();
                check("result", result, e);
            end
        end else if (sb_q.size() != 0) begin
            void'(sb_q.pop_front());
        end
        last_exp = exp;
    endtask

    // Count done pulses over n cycles; none expected after an abort.
    task automatic no_done_for(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;

        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33});
        vecs.push_back('{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1});
        vecs.push_back('{3'b100, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'b110, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 1});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33});
        vecs.push_back('{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 33});
        vecs.push_back('{3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33});
        vecs.push_back('{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33});
        vecs.push_back('{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
        vecs.push_back('{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33});

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        rst = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(f, a, b, ref_res(f, a, b), ref_lat(f, a, b));
        end

        // Flush in cycle 10 of a DIV.
        @(negedge clk);
        funct3 = 3'b100; opr_a = 32'h0000_0064; opr_b = 32'h0000_0007; start = 1'b1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_busy_calc", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result_held", result, last_exp);
        no_done_for("flush_no_done", 40);

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_busy_next", 32'(busy), 32'd0);
        no_done_for("flush_start_no_done", 5);
        check("flush_start_result", result, last_exp);

        run_op(3'b100, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        funct3 = 3'b000; opr_a = 32'h0000_0011; opr_b = 32'h0000_0003; start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        check("arst_result", result, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        no_done_for("arst_no_done", 40);

        run_op(3'b000, 32'h0000_0011, 32'h0000_0003, 32'h0000_0033, 33);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the operand A/B muxes: it consumes `opr_a`/`opr_b` when the decoded instruction is an M-extension op. It stalls the pipeline while it computes, then presents a 32-bit result to the writeback mux. Shift-add multiply and restoring divide each take one iteration per bit. Divide-by-zero and signed overflow resolve in a single cycle.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: valid M-op in execute; sampled only in IDLE.
- `funct3` in 3: op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opr_a` in XLEN: rs1 operand from the operand A mux. It is the dividend for divide ops.
- `opr_b` in XLEN: rs2 operand from the operand B mux. It is the divisor for divide ops.
- `flush` in 1: synchronous abort from branch/jump redirect.
- `busy` out 1: stall request to the pipeline; combinational.
- `done` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out XLEN: registered result; held until the next accepted `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations, 5-bit counter counting 31 down to 0.
  - DONE: `done`=1 for exactly one cycle.
- Transitions:
  - IDLE & `start` & normal op → CALC. All inputs are latched at this point: funct3, operand magnitudes, sign flags.
  - IDLE & `start` & special case → DONE. The result is loaded directly.
  - CALC & count==0 → DONE. The sign-corrected result is loaded.
  - DONE → IDLE, unconditionally.
- `flush`:
  - In any state, the next state is IDLE.
  - `done` is not asserted.
  - `result` is unchanged.
  - `flush` takes priority over `start` and over CALC completion.
- `start` outside IDLE is ignored.
- `busy` = (IDLE & `start` & !`flush`) | CALC. It is low in DONE, so the pipeline advances in the same cycle it captures `result`.
- Multiply:
  - Operands are converted to magnitudes per sign mode: MULH signed×signed, MULHSU signed×unsigned, MUL/MULHU unsigned×unsigned.
  - A 64-bit accumulator is built by shift-add.
  - The result is negated (64-bit two's complement) when the operand signs differ.
  - MUL returns bits [31:0]. The other multiply ops return bits [63:32].
- Divide:
  - Restoring division on magnitudes, using a 33-bit partial remainder.
  - Signed ops: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Special cases (no CALC):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF. REM/REMU return `opr_a`.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000. The matching REM returns 0.
- All arithmetic is modulo 2^XLEN; there is no overflow flag.

## Timing
- Reset values: state IDLE, counter 0, `result` 0x00000000, `done` 0, `busy` 0. Datapath registers are all zero.
- Normal op:
  - `start` high in cycle 0.
  - CALC in cycles 1–32.
  - `done` and valid `result` in cycle 33.
  - `busy` high in cycles 0–32.
- Special case: `start` in cycle 0; `done` in cycle 1; `busy` high in cycle 0 only.
- Back-to-back ops: the earliest next `start` is the cycle after DONE.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronously). No `done` is produced for the aborted op.

## Structure
- A shared package `mdu_pkg` holds:
  - `mdu_op_e`, an enum of the 8 funct3 encodings.
  - `mdu_state_e` (IDLE/CALC/DONE).
  - The constants `MDU_ITER` = 32 and `DIV_OVF_Q` = 0x80000000.
- One sub-module is not warranted. Negate/abs helpers are package functions, and the multiply/divide datapaths share the 64-bit shift register inside `mdu_unit`.

## Test plan
- MUL with `opr_a`=0x00000007, `opr_b`=0xFFFFFFFD → `result`=0xFFFFFFEB. `done` in cycle 33; `busy` high in cycles 0–32.
- `opr_a`=`opr_b`=0xFFFFFFFF across three multiply ops:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 0x00000002 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU with the same operands → 0x7FFFFFFC.
- Divide by zero with `opr_a`=0x00001234, `opr_b`=0:
  - DIVU → 0xFFFFFFFF and REMU → 0x00001234.
  - `done` in cycle 1; `busy` high only in cycle 0.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0x00000000. Both complete in 1 cycle.
- Abort cases:
  - `flush` in cycle 10 of a DIV: IDLE next cycle, no `done`, `result` holds its prior value. A following `start` completes correctly.
  - `rst` low mid-CALC: `result` 0, `busy` 0, `done` 0 immediately.
